vision_region_detect: RTL and testbench
=======================================

// Module: vision_region_detect
// PURPOSE
// Consumes camera_read's RGB565 pixel stream (pixel_data/pixel_valid/frame_done),
// classifies each pixel as marker/non-marker by colour threshold, counts marker pixels
// per 3x3 region and, once per frame, publishes quadrants, lane and jump with a one-cycle
// vision_data_valid strobe. Feeds camera_debug_draw and game logic in the pixel clock domain.
// PARAMETERS
// WIDTH            320     pixels per line
// HEIGHT           240     lines per frame
// R_MIN            5'd20   marker if R5 >= R_MIN
// G_MAX            6'd24   ...and G6 <= G_MAX
// B_MAX            5'd12   ...and B5 <= B_MAX
// COUNT_THRESHOLD  14'd400 region bit set if region count >= this
// PORTS
// pixel_clock_in     in   1   sole clock; all logic on rising edge
// reset_in           in   1   asynchronous, active-high reset
// pixel_data         in   16  RGB565: R=[15:11] G=[10:5] B=[4:0]
// pixel_valid        in   1   pixel_data valid this cycle
// frame_done         in   1   one-cycle end-of-frame pulse
// quadrants          out  9   bit r*3+c = region (row r, col c) over threshold; bit0 top-left
// lane               out  2   column 0..2 with most set quadrant bits
// jump               out  1   any top-row region set
// frame_error        out  1   last frame pixel count != WIDTH*HEIGHT
// vision_data_valid  out  1   one-cycle strobe: outputs updated this cycle
// BEHAVIOUR
// - Reset: quadrants=0, lane=1, jump=0, frame_error=0, vision_data_valid=0, all counters
//   and x/y position 0, FSM=ACCUM. Reset mid-frame discards the partial frame.
// - Position: x 0..WIDTH-1, y 0..HEIGHT-1, advance on pixel_valid (x wraps, y++). Pixels
//   after y reaches HEIGHT are ignored for counting but still counted in a 17-bit total.
// - Region col: x<WIDTH/3 ->0, x<2*(WIDTH/3) ->1, else 2 (106/212); rows same with HEIGHT
//   (80/160). Track col/row with boundary compares on incrementing x/y; no dividers.
// - Nine 14-bit accumulators, saturating at 16383; increment region of a marker pixel.
// - frame_done cycle: pixel_valid in the same cycle is DISCARDED (not counted, not totalled).
//   Accumulators copied to snapshot regs, total compared -> err flag, then accumulators,
//   total, x, y cleared; FSM -> EVAL. Pixels from the next cycle count toward the new frame.
// - FSM: ACCUM -(frame_done)-> EVAL -> PUBLISH -> ACCUM.
//   EVAL: q[i] = snap[i] >= COUNT_THRESHOLD; colsum[c] = q[c]+q[3+c]+q[6+c] (2 bits).
//   PUBLISH: register quadrants=q, jump=q[0]|q[1]|q[2], frame_error=err; lane=argmax
//   colsum, ties -> lowest index; all colsum 0 -> lane holds previous value;
//   vision_data_valid=1 for exactly this cycle.
// - Latency: frame_done at cycle N -> outputs + strobe at N+2. Outputs hold until next PUBLISH.
// - frame_done while in EVAL/PUBLISH: new snapshot taken, accumulators cleared, FSM -> EVAL;
//   in-flight result dropped (no strobe for it); if in PUBLISH that cycle's strobe still fires.
// - Accumulation continues in all states; only frame_done resets it.
// TESTING
// - Full frame all pixels 16'hF800 -> quadrants=9'h1FF, lane=0 (tie), jump=1, frame_error=0,
//   strobe exactly 2 cycles after frame_done.
// - Full frame black except 20x25 red block x120..139,y200..224 (500 px, region 7) ->
//   quadrants=9'h080, lane=1, jump=0.
// - Threshold edge: 399 red px in region 4 -> quadrants=0, lane unchanged; 400 -> 9'h010, lane=1.
// - Short frame of 1000 px then frame_done -> frame_error=1; frame with pixel_valid on the
//   frame_done cycle: that pixel not counted, total exactly 76800 -> frame_error=0.
// - Back-to-back frame_done 1 cycle apart -> single strobe, results from second snapshot.
// - reset_in asserted mid-frame for 1 cycle -> all outputs reset values; next full frame
//   reports correct counts unaffected by pre-reset pixels.

Source files
------------

// File: rtl/vision_region_detect.sv
// Per-frame marker detector for an RGB565 pixel stream: thresholds colour, counts marker
// pixels in a 3x3 grid and publishes quadrant/lane/jump results once per frame.
module vision_region_detect #(
  parameter int         WIDTH           = 320,
  parameter int         HEIGHT          = 240,
  parameter logic [4:0] R_MIN           = 5'd20,
  parameter logic [5:0] G_MAX           = 6'd24,
  parameter logic [4:0] B_MAX           = 5'd12,
  parameter logic [13:0] COUNT_THRESHOLD = 14'd400
) (
  input  logic        pixel_clock_in,
  input  logic        reset_in,
  input  logic [15:0] pixel_data,
  input  logic        pixel_valid,
  input  logic        frame_done,
  output logic [8:0]  quadrants,
  output logic [1:0]  lane,
  output logic        jump,
  output logic        frame_error,
  output logic        vision_data_valid
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [XW-1:0] X_B1   = XW'(WIDTH / 3);
  localparam logic [XW-1:0] X_B2   = XW'(2 * (WIDTH / 3));
  localparam logic [YW-1:0] Y_END  = YW'(HEIGHT);
  localparam logic [YW-1:0] Y_B1   = YW'(HEIGHT / 3);
  localparam logic [YW-1:0] Y_B2   = YW'(2 * (HEIGHT / 3));
  localparam logic [16:0]   FRAME_PIXELS = 17'(WIDTH * HEIGHT);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_EVAL    = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    col_q, col_d, row_q, row_d;
  logic [13:0]   acc_q [9];
  logic [13:0]   acc_d [9];
  logic [13:0]   snap_q [9];
  logic [13:0]   snap_d [9];
  logic [16:0]   total_q, total_d;
  logic          err_q, err_d;
  logic [8:0]    q_q, q_d;
  logic [1:0]    colsum_q [3];
  logic [1:0]    colsum_d [3];
  logic [8:0]    quad_q, quad_d;
  logic [1:0]    lane_q, lane_d;
  logic          jump_q, jump_d;
  logic          ferr_q, ferr_d;
  logic          valid_q, valid_d;

  logic          marker, take, count_en;
  logic [3:0]    region_idx;
  logic [XW-1:0] x_inc;
  logic [YW-1:0] y_inc;

  assign marker = (pixel_data[15:11] >= R_MIN) && (pixel_data[10:5] <= G_MAX) &&
                  (pixel_data[4:0] <= B_MAX);
  // A pixel presented together with frame_done belongs to neither frame.
  assign take       = pixel_valid && !frame_done;
  assign count_en   = take && (y_q < Y_END);
  assign region_idx = 4'(row_q) * 4'd3 + 4'(col_q);
  assign x_inc      = x_q + XW'(1);
  assign y_inc      = y_q + YW'(1);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    row_d   = row_q;
    total_d = total_q;
    err_d   = err_q;
    for (int unsigned i = 0; i < 9; i++) begin
      acc_d[i]  = acc_q[i];
      snap_d[i] = snap_q[i];
    end
    if (frame_done) begin
      x_d     = '0;
      y_d     = '0;
      col_d   = '0;
      row_d   = '0;
      total_d = '0;
      err_d   = (total_q != FRAME_PIXELS);
      for (int unsigned i = 0; i < 9; i++) begin
        snap_d[i] = acc_q[i];
        acc_d[i]  = '0;
      end
    end else begin
      if (take && (total_q != '1)) total_d = total_q + 17'd1;
      if (count_en) begin
        if (marker && (acc_q[region_idx] != '1))
          acc_d[region_idx] = acc_q[region_idx] + 14'd1;
        if (x_q == X_LAST) begin
          x_d   = '0;
          col_d = 2'd0;
          y_d   = y_inc;
          if (y_inc == Y_B1) row_d = 2'd1;
          else if (y_inc == Y_B2) row_d = 2'd2;
        end else begin
          x_d = x_inc;
          if (x_inc == X_B1) col_d = 2'd1;
          else if (x_inc == X_B2) col_d = 2'd2;
        end
      end
    end
  end

  always_comb begin
    state_d = ST_ACCUM;
    if (frame_done) state_d = ST_EVAL;
    else if (state_q == ST_EVAL) state_d = ST_PUBLISH;
  end

  always_comb begin
    q_d = q_q;
    for (int unsigned c = 0; c < 3; c++) colsum_d[c] = colsum_q[c];
    if (state_q == ST_EVAL) begin
      for (int unsigned i = 0; i < 9; i++) q_d[i] = (snap_q[i] >= COUNT_THRESHOLD);
      for (int unsigned c = 0; c < 3; c++)
        colsum_d[c] = 2'(q_d[c]) + 2'(q_d[3+c]) + 2'(q_d[6+c]);
    end
  end

  always_comb begin
    quad_d  = quad_q;
    lane_d  = lane_q;
    jump_d  = jump_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    if (state_q == ST_PUBLISH) begin
      quad_d  = q_q;
      jump_d  = |q_q[2:0];
      ferr_d  = err_q;
      valid_d = 1'b1;
      // Ties go to the lowest column; an empty grid keeps the previous lane.
      if ((colsum_q[0] | colsum_q[1] | colsum_q[2]) != 2'd0) begin
        if ((colsum_q[0] >= colsum_q[1]) && (colsum_q[0] >= colsum_q[2])) lane_d = 2'd0;
        else if (colsum_q[1] >= colsum_q[2]) lane_d = 2'd1;
        else lane_d = 2'd2;
      end
    end
  end

  always_ff @(posedge pixel_clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_ACCUM;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
      q_q     <= '0;
      quad_q  <= '0;
      lane_q  <= 2'd1;
      jump_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) begin
        acc_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      for (int unsigned c = 0; c < 3; c++) colsum_q[c] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      row_q   <= row_d;
      total_q <= total_d;
      err_q   <= err_d;
      q_q     <= q_d;
      quad_q  <= quad_d;
      lane_q  <= lane_d;
      jump_q  <= jump_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      for (int unsigned i = 0; i < 9; i++) begin
        acc_q[i]  <= acc_d[i];
        snap_q[i] <= snap_d[i];
      end
      for (int unsigned c = 0; c < 3; c++) colsum_q[c] <= colsum_d[c];
    end
  end

  assign quadrants         = quad_q;
  assign lane              = lane_q;
  assign jump              = jump_q;
  assign frame_error       = ferr_q;
  assign vision_data_valid = valid_q;

endmodule

// File: tb/tb_vision_region_detect.sv
// Directed frame-level checks of vision_region_detect on a reduced 30x24 frame
// (regions 10x8 pixels, threshold 40) so full frames stay short.
module tb_vision_region_detect;

  localparam int W = 30;
  localparam int H = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        frame_done;
  logic [8:0]  quadrants;
  logic [1:0]  lane;
  logic        jump;
  logic        frame_error;
  logic        vision_data_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  vision_region_detect #(
    .WIDTH(W),
    .HEIGHT(H),
    .R_MIN(5'd20),
    .G_MAX(6'd24),
    .B_MAX(5'd12),
    .COUNT_THRESHOLD(14'd40)
  ) dut (
    .pixel_clock_in(clk),
    .reset_in(rst),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .frame_done(frame_done),
    .quadrants(quadrants),
    .lane(lane),
    .jump(jump),
    .frame_error(frame_error),
    .vision_data_valid(vision_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x0, x1, y0, y1;  // marker rectangle
    int          rmax;            // max marker pixels drawn inside it
    int          npix;            // pixels sent before frame_done
    bit          fd_pix;          // pixel_valid also high on the frame_done cycle
    logic [15:0] fg, bg;
    logic [8:0]  quad;
    logic [1:0]  lane;
    logic        jump, err;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic send_pixels(input vec_t v);
    int red = 0;
    for (int p = 0; p < v.npix; p++) begin
      int  x = p % W;
      int  y = p / W;
      bit  in_r = (x >= v.x0) && (x <= v.x1) && (y >= v.y0) && (y <= v.y1) && (red < v.rmax);
      if (in_r) red++;
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_data  = in_r ? v.fg : v.bg;
      if (p % 7 == 3) begin
        @(negedge clk);
        pixel_valid = 1'b0;
        pixel_data  = 16'hF800;
      end
    end
  endtask

  // Call right after the (last) frame_done has been driven for one cycle.
  task automatic expect_publish(input vec_t v, input int id);
    int first = -1;
    int strobes = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        frame_done  = 1'b0;
        pixel_valid = 1'b0;
      end
      if (vision_data_valid) begin
        strobes++;
        if (first < 0) first = k - 1;
      end
    end
    check("latency", id, 32'(first), 32'd2);
    check("strobes", id, 32'(strobes), 32'd1);
    check("quadrants", id, 32'(quadrants), 32'(v.quad));
    check("lane", id, 32'(lane), 32'(v.lane));
    check("jump", id, 32'(jump), 32'(v.jump));
    check("frame_error", id, 32'(frame_error), 32'(v.err));
  endtask

  task automatic run_frame(input vec_t v, input int id);
    send_pixels(v);
    @(negedge clk);
    frame_done  = 1'b1;
    pixel_valid = v.fd_pix;
    pixel_data  = 16'hF800;
    expect_publish(v, id);
  endtask

  task automatic check_reset_outputs(input int id);
    check("rst_quadrants", id, 32'(quadrants), 32'd0);
    check("rst_lane", id, 32'(lane), 32'd1);
    check("rst_jump", id, 32'(jump), 32'd0);
    check("rst_frame_error", id, 32'(frame_error), 32'd0);
    check("rst_valid", id, 32'(vision_data_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    // x0 x1 y0 y1 rmax npix fd fg bg quad lane jump err
    tbl[0] = '{0, 29, 0, 23, 720, 720, 1'b0, 16'hF800, 16'h0000, 9'h1FF, 2'd0, 1'b1, 1'b0};
    tbl[1] = '{10, 19, 16, 20, 1000, 720, 1'b0, 16'hF800, 16'hF80D, 9'h080, 2'd1, 1'b0, 1'b0};
    tbl[2] = '{20, 29, 0, 7, 1000, 720, 1'b0, 16'hF800, 16'h0000, 9'h004, 2'd2, 1'b1, 1'b0};
    tbl[3] = '{10, 19, 8, 15, 39, 720, 1'b0, 16'hF800, 16'hFB20, 9'h000, 2'd2, 1'b0, 1'b0};
    tbl[4] = '{10, 19, 8, 15, 40, 720, 1'b0, 16'hA30C, 16'h9800, 9'h010, 2'd1, 1'b0, 1'b0};
    tbl[5] = '{0, -1, 0, -1, 0, 100, 1'b0, 16'hF800, 16'hFB20, 9'h000, 2'd1, 1'b0, 1'b1};
    tbl[6] = '{0, -1, 0, -1, 0, 720, 1'b1, 16'hF800, 16'h0000, 9'h000, 2'd1, 1'b0, 1'b0};
    tbl[7] = '{0, 9, 0, 7, 39, 720, 1'b0, 16'hF800, 16'h0000, 9'h000, 2'd1, 1'b0, 1'b0};
    tbl[8] = '{0, -1, 0, -1, 0, 721, 1'b0, 16'hF800, 16'h0000, 9'h000, 2'd1, 1'b0, 1'b1};
    tbl[9] = '{10, 29, 0, 7, 1000, 720, 1'b0, 16'hF800, 16'h0000, 9'h006, 2'd1, 1'b1, 1'b0};

    rst         = 1'b1;
    pixel_valid = 1'b0;
    frame_done  = 1'b0;
    pixel_data  = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs(0);

    for (int i = 0; i < 10; i++) run_frame(tbl[i], i);

    // Back-to-back frame_done: second (empty) snapshot wins, one strobe, lane held.
    v = tbl[0];
    send_pixels(v);
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b1;
    v.quad = 9'h000; v.lane = 2'd1; v.jump = 1'b0; v.err = 1'b1;
    expect_publish(v, 20);

    // Mid-frame reset: partial red frame discarded, outputs back to reset values.
    run_frame(tbl[0], 21);
    v = tbl[0];
    v.npix = 360;
    send_pixels(v);
    @(negedge clk);
    rst         = 1'b1;
    pixel_valid = 1'b1;
    pixel_data  = 16'hF800;
    @(negedge clk);
    rst         = 1'b0;
    pixel_valid = 1'b0;
    check_reset_outputs(22);
    run_frame(tbl[1], 23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
